// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staged reset release controller.
//
// After srst deasserts (or a sw_rst restart), waits POR_DLY cycles, releases
// stage 0, then for each following stage waits for the previous stage's
// ready flag plus STAGE_DLY cycles before releasing it.
//
// Optional feature, macro RST_SEQ_TIMEOUT_EN: each released stage gets TMO_CYC
// cycles to report ready. A timeout re-asserts that stage's reset and retries
// it (up to RETRY_MAX times) before declaring failure.
//
// Ports:
//   clk        in   PLL domain clock
//   srst       in   synchronous active-high reset
//   sw_rst     in   level-sampled restart request
//   stage_rdy  in   [NUM_STAGES] per-stage ready flags
//   rst_out    out  [NUM_STAGES] per-stage reset, active-high, bit 0 first
//   busy       out  sequence in progress
//   seq_done   out  all stages released and ready
//   seq_fail   out  a stage failed after retries (0 without the macro)
//   fail_stage out  index of the failed stage (0 without the macro)
module rst_seq_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int POR_DLY    = 4096,
    parameter int STAGE_DLY  = 1024,
    parameter int TMO_CYC    = 1048576,
    parameter int RETRY_MAX  = 3
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  sw_rst,
    input  logic [NUM_STAGES-1:0] stage_rdy,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_fail,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] fail_stage
);

    localparam int unsigned KW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int          MAX_PS = (POR_DLY > STAGE_DLY) ? POR_DLY : STAGE_DLY;
    localparam int          MAX_D  = (MAX_PS > TMO_CYC) ? MAX_PS : TMO_CYC;
    localparam int unsigned CW     = $clog2(MAX_D) + 1;

    // Elaboration-time guard on parameter ranges
    if (NUM_STAGES < 1 || POR_DLY < 1 || STAGE_DLY < 1 || TMO_CYC < 1 || RETRY_MAX < 0)
    begin : g_param_check
        $error("rst_seq_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_POR,
        S_WAIT,
        S_DLY,
        S_DONE
`ifdef RST_SEQ_TIMEOUT_EN
        ,
        S_RETRY,
        S_FAIL
`endif
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_inc;
    logic [KW-1:0]  k_q;

    // Saturating increment: the counter never wraps
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RW-1:0] retry_q;
`else
    assign seq_fail   = 1'b0;
    assign fail_stage = '0;
`endif

    // Sequencer: state, counter, stage index and all registered outputs
    always_ff @(posedge clk) begin
        if (srst || sw_rst) begin
            state_q  <= S_POR;
            cnt_q    <= '0;
            k_q      <= '0;
            rst_out  <= '1;
            busy     <= 1'b1;
            seq_done <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            retry_q    <= '0;
            seq_fail   <= 1'b0;
            fail_stage <= '0;
`endif
        end else begin
            case (state_q)
                S_POR: begin
                    if (cnt_q == CW'(POR_DLY)) begin
                        rst_out[0] <= 1'b0;
                        cnt_q      <= '0;
                        k_q        <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_WAIT: begin
                    // Only the current stage's ready bit is observed
                    if (stage_rdy[k_q]) begin
`ifdef RST_SEQ_TIMEOUT_EN
                        retry_q <= '0;
`endif
                        if (k_q == KW'(NUM_STAGES - 1)) begin
                            busy     <= 1'b0;
                            seq_done <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            k_q     <= k_q + KW'(1);
                            cnt_q   <= '0;
                            state_q <= S_DLY;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == CW'(TMO_CYC - 1)) begin
                        rst_out[k_q] <= 1'b1;
                        cnt_q        <= '0;
                        if (retry_q == RW'(RETRY_MAX)) begin
                            seq_fail   <= 1'b1;
                            fail_stage <= k_q;
                            busy       <= 1'b0;
                            state_q    <= S_FAIL;
                        end else begin
                            retry_q <= retry_q + RW'(1);
                            state_q <= S_RETRY;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
`endif
                end
`ifdef RST_SEQ_TIMEOUT_EN
                S_DLY, S_RETRY: begin
`else
                S_DLY: begin
`endif
                    // Counter was cleared on entry, so release lands STAGE_DLY edges later
                    if (cnt_q == CW'(STAGE_DLY - 1)) begin
                        rst_out[k_q] <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    // S_FAIL holds; unreachable encodings fall back to S_POR
`ifdef RST_SEQ_TIMEOUT_EN
                    if (state_q != S_FAIL) begin
                        state_q <= S_POR;
                    end
`else
                    state_q <= S_POR;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with NUM_STAGES=3, POR_DLY=8, STAGE_DLY=4,
// TMO_CYC=16, RETRY_MAX=2. Edge numbers are counted from E0, the first edge
// that samples srst (or sw_rst) low.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       srst;
    logic       sw_rst;
    logic [2:0] stage_rdy;
    logic [2:0] rst_out;
    logic       busy;
    logic       seq_done;
    logic       seq_fail;
    logic [1:0] fail_stage;

    int checks = 0;
    int errors = 0;
    int e      = -1;

    typedef struct {
        string      nm;
        int         ev;
        logic [2:0] rdy;    // stage_rdy driven after this check
        logic [2:0] rst;
        logic       busy;
        logic       done;
        logic       fail;
        logic [1:0] fs;
    } vec_t;

    vec_t nom_t[8];
`ifdef RST_SEQ_TIMEOUT_EN
    vec_t tmo_t[12];
`else
    vec_t stl_t[9];
`endif

    rst_seq_ctrl #(
        .NUM_STAGES(3),
        .POR_DLY   (8),
        .STAGE_DLY (4),
        .TMO_CYC   (16),
        .RETRY_MAX (2)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .sw_rst    (sw_rst),
        .stage_rdy (stage_rdy),
        .rst_out   (rst_out),
        .busy      (busy),
        .seq_done  (seq_done),
        .seq_fail  (seq_fail),
        .fail_stage(fail_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic advance_to(input int ev);
        while (e < ev) tick();
    endtask

    task automatic check(input string nm, input logic [2:0] xr, input logic xb,
                         input logic xd, input logic xf, input logic [1:0] xs);
        checks++;
        if (rst_out !== xr || busy !== xb || seq_done !== xd ||
            seq_fail !== xf || fail_stage !== xs) begin
            errors++;
            $display("FAIL %s e=%0d got rst=%b busy=%b done=%b fail=%b fs=%0d want rst=%b busy=%b done=%b fail=%b fs=%0d",
                     nm, e, rst_out, busy, seq_done, seq_fail, fail_stage, xr, xb, xd, xf, xs);
        end
    endtask

    task automatic run_vec(input vec_t v);
        advance_to(v.ev);
        check(v.nm, v.rst, v.busy, v.done, v.fail, v.fs);
        stage_rdy = v.rdy;
    endtask

    // One-cycle srst pulse; the following edge becomes the new E0
    task automatic srst_pulse();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        e = -1;
    endtask

    initial begin
        nom_t[0] = '{"nom_e7",  7,  3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[1] = '{"nom_s0",  8,  3'b111, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[2] = '{"nom_e12", 12, 3'b111, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[3] = '{"nom_s1",  13, 3'b111, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[4] = '{"nom_e17", 17, 3'b111, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[5] = '{"nom_s2",  18, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0};
        nom_t[6] = '{"nom_done",19, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0};
        nom_t[7] = '{"nom_hold",25, 3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0};
`ifdef RST_SEQ_TIMEOUT_EN
        tmo_t[0]  = '{"tmo_s1",   13, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[1]  = '{"tmo_e28",  28, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[2]  = '{"tmo_to1",  29, 3'b101, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[3]  = '{"tmo_e32",  32, 3'b101, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[4]  = '{"tmo_rel1", 33, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[5]  = '{"tmo_e48",  48, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[6]  = '{"tmo_to2",  49, 3'b101, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[7]  = '{"tmo_e52",  52, 3'b101, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[8]  = '{"tmo_rel2", 53, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[9]  = '{"tmo_e68",  68, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        tmo_t[10] = '{"tmo_fail", 69, 3'b101, 3'b110, 1'b0, 1'b0, 1'b1, 2'd1};
        tmo_t[11] = '{"tmo_hold", 90, 3'b111, 3'b110, 1'b0, 1'b0, 1'b1, 2'd1};
`else
        // bit 0 drops after stage 0 passed; bit 2 high early; both must be ignored
        stl_t[0] = '{"stl_s0",   8,  3'b101, 3'b110, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[1] = '{"stl_s1",   13, 3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[2] = '{"stl_drop", 20, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[3] = '{"stl_e30",  30, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[4] = '{"stl_e40",  40, 3'b110, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[5] = '{"stl_w",    41, 3'b110, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[6] = '{"stl_e44",  44, 3'b110, 3'b100, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[7] = '{"stl_s2",   45, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0};
        stl_t[8] = '{"stl_done", 46, 3'b110, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0};
`endif

        srst      = 1'b1;
        sw_rst    = 1'b0;
        stage_rdy = 3'b000;
        repeat (3) tick();
        check("reset", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);

        // Nominal sequence
        srst      = 1'b0;
        e         = -1;
        stage_rdy = 3'b111;
        foreach (nom_t[i]) run_vec(nom_t[i]);

        // srst for one cycle in S_DONE
        srst = 1'b1;
        tick();
        check("srst_done", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        srst = 1'b0;
        e    = -1;

`ifdef RST_SEQ_TIMEOUT_EN
        stage_rdy = 3'b101;
        foreach (tmo_t[i]) run_vec(tmo_t[i]);
`else
        stage_rdy = 3'b101;
        foreach (stl_t[i]) run_vec(stl_t[i]);
`endif

        // sw_rst pulse while stage 1 is released
        stage_rdy = 3'b111;
        srst_pulse();
        advance_to(14);
        check("sw_pre", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
        sw_rst = 1'b1;
        tick();
        check("sw_hit", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        sw_rst = 1'b0;
        tick();
        check("sw_e16", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(23);
        check("sw_e23", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(24);
        check("sw_s0", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(29);
        check("sw_s1", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(34);
        check("sw_s2", 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(35);
        check("sw_done", 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);

        // sw_rst held: counter stays at 0 until it is sampled low
        sw_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sw_held", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        end
        sw_rst = 1'b0;
        e      = -1;
        advance_to(7);
        check("swh_e7", 3'b111, 1'b1, 1'b0, 1'b0, 2'd0);
        advance_to(8);
        check("swh_s0", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);

`ifndef RST_SEQ_TIMEOUT_EN
        // Without supervision, a missing ready just waits
        stage_rdy = 3'b110;
        srst_pulse();
        for (int ev = 8; ev <= 500; ev += 20) begin
            advance_to(ev);
            check("nto_wait", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        end
        advance_to(500);
        check("nto_e500", 3'b110, 1'b1, 1'b0, 1'b0, 2'd0);
        stage_rdy = 3'b111;
        advance_to(505);
        check("nto_s1", 3'b100, 1'b1, 1'b0, 1'b0, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
